// File: rtl/tc_delay_tap.sv
// Multi-tick delay line with a selectable read tap over a circular history buffer.
// Optional TC_DELAY_TAP_EVICT_EN exposes the sample about to be overwritten, for cascading.
module tc_delay_tap #(
    parameter int UUID      = 0,
    parameter     NAME      = "",
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int TAP_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [BIT_WIDTH-1:0] in,
    input  logic [TAP_W-1:0]     tap,
    output logic [BIT_WIDTH-1:0] out,
    output logic                 out_valid,
    output logic                 tap_err,
`ifdef TC_DELAY_TAP_EVICT_EN
    output logic                 evict_valid,
    output logic [BIT_WIDTH-1:0] evict_data,
`endif
    output logic                 full
);

    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int IW     = TAP_W + 2;

    logic [BIT_WIDTH-1:0] ring_q [DEPTH];
    logic [BIT_WIDTH-1:0] ring_d [DEPTH];
    logic [TAP_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;

    logic [IW-1:0]        back;
    logic [IW-1:0]        rd_wide;
    logic [TAP_W-1:0]     rd_idx;

    always_comb begin
        ring_d   = ring_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (en && !rst) begin
            ring_d[wr_ptr_q] = in;
            wr_ptr_d = (wr_ptr_q == TAP_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            fill_d   = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + 1'b1;
        end
    end

    // Ring contents survive reset; reads are gated by fill so stale data never leaks.
    always_ff @(posedge clk) begin
        ring_q <= ring_d;
        if (rst) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    assign full    = (fill_q == FILL_W'(DEPTH));
    assign tap_err = (IW'(tap) >= IW'(DEPTH));

    // Read index = (wr_ptr - 1 - tap) mod DEPTH with explicit wrap so odd DEPTH works.
    always_comb begin
        back = IW'(tap) + IW'(1);
        if (IW'(wr_ptr_q) >= back)
            rd_wide = IW'(wr_ptr_q) - back;
        else
            rd_wide = IW'(wr_ptr_q) + IW'(DEPTH) - back;
        rd_idx = tap_err ? '0 : rd_wide[TAP_W-1:0];
    end

    assign out_valid = !tap_err && (IW'(tap) < IW'(fill_q));
    assign out       = out_valid ? ring_q[rd_idx] : '0;

`ifdef TC_DELAY_TAP_EVICT_EN
    // When full, the write slot holds the oldest sample.
    assign evict_valid = en && !rst && full;
    assign evict_data  = evict_valid ? ring_q[wr_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_tc_delay_tap.sv
// Self-checking bench for tc_delay_tap: a DEPTH=8 and a DEPTH=5 instance share stimulus
// and are compared against a queue-based history model.
module tb_tc_delay_tap;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] din = 8'd0;
    logic [2:0] tap8 = 3'd0, tap5 = 3'd0;
    logic [7:0] out8, out5;
    logic       ov8, ov5, te8, te5, full8, full5;
`ifdef TC_DELAY_TAP_EVICT_EN
    logic       ev8, ev5;
    logic [7:0] evd8, evd5;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] hist [$];

    always #50 clk = ~clk;

    tc_delay_tap #(.UUID(1), .NAME("d8"), .BIT_WIDTH(8), .DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .en(en), .in(din), .tap(tap8),
        .out(out8), .out_valid(ov8), .tap_err(te8),
`ifdef TC_DELAY_TAP_EVICT_EN
        .evict_valid(ev8), .evict_data(evd8),
`endif
        .full(full8));

    tc_delay_tap #(.UUID(2), .NAME("d5"), .BIT_WIDTH(8), .DEPTH(5)) u5 (
        .clk(clk), .rst(rst), .en(en), .in(din), .tap(tap5),
        .out(out5), .out_valid(ov5), .tap_err(te5),
`ifdef TC_DELAY_TAP_EVICT_EN
        .evict_valid(ev5), .evict_data(evd5),
`endif
        .full(full5));

    function automatic int fill_of(int d);
        return (hist.size() < d) ? hist.size() : d;
    endfunction

    function automatic logic exp_valid(int d, int t);
        return (t < d) && (t < fill_of(d));
    endfunction

    function automatic logic [7:0] exp_out(int d, int t);
        return exp_valid(d, t) ? hist[t] : 8'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) hist.delete();
        else if (en) begin
            hist.push_front(din);
            if (hist.size() > 300) void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; tick(); rst = 0;
        for (int t = 0; t < 8; t++) begin
            tap8 = 3'(t); tap5 = 3'(t); #1;
            checks++;
            if (ov8 !== 1'b0 || out8 !== 8'd0 || ov5 !== 1'b0 || out5 !== 8'd0) begin
                errors++;
                $display("FAIL reset_out tap=%0d got ov8=%b out8=%h ov5=%b out5=%h want 0", t, ov8, out8, ov5, out5);
            end
            checks++;
            if (te5 !== (t >= 5) || te8 !== 1'b0) begin
                errors++;
                $display("FAIL reset_taperr tap=%0d got te5=%b te8=%b want %b 0", t, te5, te8, t >= 5);
            end
        end
        checks++;
        if (full8 !== 1'b0 || full5 !== 1'b0) begin
            errors++; $display("FAIL reset_full got %b %b want 0 0", full8, full5);
        end
    endtask

    task automatic test_fill();
        rst = 1; tick(); rst = 0; en = 1;
        for (int v = 1; v <= 3; v++) begin din = 8'(v); tick(); end
        en = 0;
        tap8 = 0; #1; checks++;
        if (out8 !== 8'd3 || ov8 !== 1'b1) begin
            errors++; $display("FAIL fill_tap0 got %h/%b want 03/1", out8, ov8);
        end
        tap8 = 2; #1; checks++;
        if (out8 !== 8'd1 || ov8 !== 1'b1) begin
            errors++; $display("FAIL fill_tap2 got %h/%b want 01/1", out8, ov8);
        end
        tap8 = 3; #1; checks++;
        if (out8 !== 8'd0 || ov8 !== 1'b0) begin
            errors++; $display("FAIL fill_tap3 got %h/%b want 00/0", out8, ov8);
        end
    endtask

    task automatic test_wrap();
        rst = 1; tick(); rst = 0; en = 1;
        for (int v = 10; v <= 21; v++) begin din = 8'(v); tick(); end
        en = 0;
        checks++;
        if (full8 !== 1'b1 || full5 !== 1'b1) begin
            errors++; $display("FAIL wrap_full got %b %b want 1 1", full8, full5);
        end
        tap8 = 0; #1; checks++;
        if (out8 !== 8'd21) begin errors++; $display("FAIL wrap_tap0 got %0d want 21", out8); end
        tap8 = 7; #1; checks++;
        if (out8 !== 8'd14) begin errors++; $display("FAIL wrap_tap7 got %0d want 14", out8); end
        tap5 = 4; #1; checks++;
        if (out5 !== 8'd17) begin errors++; $display("FAIL wrap_d5_tap4 got %0d want 17", out5); end
        for (int t = 0; t < 8; t++) begin
            tap8 = 3'(t); #1; checks++;
            if (ov8 !== 1'b1 || out8 !== 8'(21 - t)) begin
                errors++; $display("FAIL wrap_sweep tap=%0d got %0d/%b want %0d/1", t, out8, ov8, 21 - t);
            end
        end
    endtask

    task automatic test_stall();
        rst = 1; tick(); rst = 0; en = 1;
        din = 5; tick(); din = 6; tick();
        en = 0; din = 99;
        for (int c = 0; c < 4; c++) begin
            tick();
            tap8 = 0; tap5 = 1; #1; checks++;
            if (out8 !== 8'd6 || out5 !== 8'd5) begin
                errors++; $display("FAIL stall_hold cyc=%0d got %0d %0d want 6 5", c, out8, out5);
            end
            tap8 = 2; #1; checks++;
            if (ov8 !== 1'b0 || full8 !== 1'b0) begin
                errors++; $display("FAIL stall_fill cyc=%0d got ov=%b full=%b want 0 0", c, ov8, full8);
            end
        end
    endtask

    task automatic test_nonpow2();
        rst = 1; tick(); rst = 0; en = 1;
        for (int v = 1; v <= 7; v++) begin din = 8'(v); tick(); end
        en = 0;
        tap5 = 4; #1; checks++;
        if (out5 !== 8'd3 || ov5 !== 1'b1 || te5 !== 1'b0 || full5 !== 1'b1) begin
            errors++; $display("FAIL np2_tap4 got %0d/%b/%b/%b want 3/1/0/1", out5, ov5, te5, full5);
        end
        for (int t = 5; t < 8; t++) begin
            tap5 = 3'(t); #1; checks++;
            if (te5 !== 1'b1 || out5 !== 8'd0 || ov5 !== 1'b0) begin
                errors++; $display("FAIL np2_taperr tap=%0d got te=%b out=%0d ov=%b want 1/0/0", t, te5, out5, ov5);
            end
        end
        tap8 = 6; #1; checks++;
        if (out8 !== 8'd1 || ov8 !== 1'b1) begin errors++; $display("FAIL np2_d8_tap6 got %0d/%b want 1/1", out8, ov8); end
        tap8 = 7; #1; checks++;
        if (ov8 !== 1'b0 || full8 !== 1'b0) begin errors++; $display("FAIL np2_d8_tap7 got ov=%b full=%b want 0 0", ov8, full8); end
    endtask

    task automatic test_reset_priority();
        en = 1;
        for (int v = 0; v < 8; v++) begin din = 8'(8'h30 + v); tick(); end
        rst = 1; en = 1; din = 8'hAA; tick(); rst = 0; en = 0;
        for (int t = 0; t < 8; t++) begin
            tap8 = 3'(t); tap5 = 3'(t); #1; checks++;
            if (ov8 !== 1'b0 || out8 !== 8'd0 || ov5 !== 1'b0 || out5 !== 8'd0) begin
                errors++; $display("FAIL rstpri_clear tap=%0d got %b/%h %b/%h want 0/00", t, ov8, out8, ov5, out5);
            end
        end
        checks++;
        if (full8 !== 1'b0 || full5 !== 1'b0) begin errors++; $display("FAIL rstpri_full got %b %b want 0 0", full8, full5); end
        en = 1; din = 8'h55; tick(); en = 0;
        tap8 = 0; tap5 = 1; #1; checks++;
        if (out8 !== 8'h55 || ov8 !== 1'b1 || ov5 !== 1'b0 || out5 !== 8'd0) begin
            errors++; $display("FAIL rstpri_restart got %h/%b %h/%b want 55/1 00/0", out8, ov8, out5, ov5);
        end
    endtask

`ifdef TC_DELAY_TAP_EVICT_EN
    task automatic test_evict();
        rst = 1; tick(); rst = 0; en = 1;
        for (int v = 1; v <= 5; v++) begin din = 8'(v); tick(); end
        din = 9; #1; checks++;
        if (ev5 !== 1'b1 || evd5 !== 8'd1 || ev8 !== 1'b0 || evd8 !== 8'd0) begin
            errors++; $display("FAIL evict_pre got %b/%0d %b/%0d want 1/1 0/0", ev5, evd5, ev8, evd8);
        end
        tick(); en = 0; #1; checks++;
        if (ev5 !== 1'b0 || evd5 !== 8'd0) begin errors++; $display("FAIL evict_idle got %b/%0d want 0/0", ev5, evd5); end
        tap5 = 4; #1; checks++;
        if (out5 !== 8'd2) begin errors++; $display("FAIL evict_post got %0d want 2", out5); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 4);
            en  = ($urandom_range(0, 99) < 70);
            din = 8'($urandom);
            #1;
`ifdef TC_DELAY_TAP_EVICT_EN
            checks++;
            if (ev8 !== (en && !rst && fill_of(8) == 8) ||
                evd8 !== ((en && !rst && fill_of(8) == 8) ? hist[7] : 8'd0)) begin
                errors++; $display("FAIL rand_evict8 cyc=%0d got %b/%h", c, ev8, evd8);
            end
            checks++;
            if (ev5 !== (en && !rst && fill_of(5) == 5) ||
                evd5 !== ((en && !rst && fill_of(5) == 5) ? hist[4] : 8'd0)) begin
                errors++; $display("FAIL rand_evict5 cyc=%0d got %b/%h", c, ev5, evd5);
            end
`endif
            tick();
            for (int t = 0; t < 8; t++) begin
                tap8 = 3'(t); tap5 = 3'($urandom_range(0, 7)); #1;
                checks++;
                if (out8 !== exp_out(8, t) || ov8 !== exp_valid(8, t) || full8 !== (fill_of(8) == 8)) begin
                    errors++; $display("FAIL rand_d8 cyc=%0d tap=%0d got %h/%b/%b want %h/%b/%b", c, t,
                                       out8, ov8, full8, exp_out(8, t), exp_valid(8, t), fill_of(8) == 8);
                end
                checks++;
                if (out5 !== exp_out(5, int'(tap5)) || ov5 !== exp_valid(5, int'(tap5)) ||
                    te5 !== (tap5 >= 3'd5) || full5 !== (fill_of(5) == 5)) begin
                    errors++; $display("FAIL rand_d5 cyc=%0d tap=%0d got %h/%b/%b/%b want %h/%b", c, tap5,
                                       out5, ov5, te5, full5, exp_out(5, int'(tap5)), exp_valid(5, int'(tap5)));
                end
            end
        end
        rst = 0; en = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_stall();
        test_nonpow2();
        test_reset_priority();
`ifdef TC_DELAY_TAP_EVICT_EN
        test_evict();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
